// File: rtl/am9513_cai_decoder_if.sv
// Submit-descriptor and micro-op buses for the CAI decode stage.
// slave = decoder side, master = producer/consumer side.
interface am9513_cai_decoder_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_opcode;
    logic [31:0] s_flags;
    logic [95:0] s_opnd_flags;
    logic [7:0]  s_tag;

    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_func;
    logic [7:0]  m_fmt;
    logic [7:0]  m_src_fmt;
    logic [1:0]  m_mode;
    logic        m_res_reg_vld;
    logic [3:0]  m_res_reg;
    logic [2:0]  m_opnd_is_reg;
    logic [11:0] m_opnd_reg;
    logic [7:0]  m_tag;
    logic        m_err;
    logic [2:0]  m_err_code;

    modport slave (
        input  s_valid, s_opcode, s_flags, s_opnd_flags, s_tag, m_ready,
        output s_ready, m_valid, m_func, m_fmt, m_src_fmt, m_mode,
               m_res_reg_vld, m_res_reg, m_opnd_is_reg, m_opnd_reg,
               m_tag, m_err, m_err_code
    );

    modport master (
        output s_valid, s_opcode, s_flags, s_opnd_flags, s_tag, m_ready,
        input  s_ready, m_valid, m_func, m_fmt, m_src_fmt, m_mode,
               m_res_reg_vld, m_res_reg, m_opnd_is_reg, m_opnd_reg,
               m_tag, m_err, m_err_code
    );
endinterface

// File: rtl/am9513_cai_decoder.sv
// Am9513 CAI decode stage: validates a submit descriptor and registers a decoded
// micro-op (or an errored pass-through) with single-cycle latency.
module am9513_cai_decoder (
    input  logic                        clk,
    input  logic                        rst,
    am9513_cai_decoder_if.slave         bus,
    input  logic [1:0]                  cur_mode,
    input  logic                        cnt_clr,
    output logic [15:0]                 dec_cnt,
    output logic [15:0]                 err_cnt
);
    localparam logic [2:0] ERR_OK         = 3'd0;
    localparam logic [2:0] ERR_NOT_VENDOR = 3'd1;
    localparam logic [2:0] ERR_RSVD       = 3'd2;
    localparam logic [2:0] ERR_BAD_FUNC   = 3'd3;
    localparam logic [2:0] ERR_BAD_FMT    = 3'd4;
    localparam logic [2:0] ERR_BAD_MODE   = 3'd5;
    localparam logic [2:0] ERR_TIER       = 3'd6;
    localparam logic [7:0] FUNC_CONV      = 8'h10;

    logic        accept;
    logic [7:0]  func, fmt, src_fmt;
    logic        is_conv, func_legal, tier_ok;
    logic [2:0]  mode_raw;
    logic [2:0]  err_code;
    logic        res_vld;
    logic [3:0]  res_reg;
    logic [2:0]  opnd_is_reg;
    logic [11:0] opnd_reg;

    wire unused_bits = ^{bus.s_flags[31:12],
                         bus.s_opnd_flags[95:76], bus.s_opnd_flags[71:65],
                         bus.s_opnd_flags[63:44], bus.s_opnd_flags[39:33],
                         bus.s_opnd_flags[31:12], bus.s_opnd_flags[7:1]};

    assign bus.s_ready = !rst && (!bus.m_valid || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;

    assign func    = bus.s_opcode[7:0];
    assign fmt     = bus.s_opcode[15:8];
    assign is_conv = (func == FUNC_CONV);

    always_comb begin
        src_fmt     = 8'h00;
        res_vld     = 1'b0;
        res_reg     = 4'h0;
        mode_raw    = {1'b0, cur_mode};
        // CONV reuses the mode/result-register flag bits for the source format
        if (is_conv) begin
            src_fmt = bus.s_flags[7:0];
        end else begin
            res_vld = bus.s_flags[4];
            res_reg = bus.s_flags[11:8];
            if (bus.s_flags[0])
                mode_raw = bus.s_flags[3:1];
        end
        for (int i = 0; i < 3; i++) begin
            opnd_is_reg[i]   = bus.s_opnd_flags[32*i];
            opnd_reg[4*i+:4] = bus.s_opnd_flags[32*i] ? bus.s_opnd_flags[32*i+8+:4] : 4'h0;
        end
    end

    always_comb begin
        func_legal = ((func >= 8'h01) && (func <= 8'h0A)) ||
                     ((func >= 8'h10) && (func <= 8'h14)) ||
                     ((func >= 8'h20) && (func <= 8'h27));
        case (mode_raw)
            3'd0:    tier_ok = ((func >= 8'h01) && (func <= 8'h05)) ||
                               ((func >= 8'h10) && (func <= 8'h14)) ||
                               ((func >= 8'h20) && (func <= 8'h25));
            3'd1:    tier_ok = ((func >= 8'h01) && (func <= 8'h05)) || (func == 8'h10);
            3'd2:    tier_ok = func_legal;
            default: tier_ok = 1'b0;
        endcase

        if (!bus.s_opcode[31])                          err_code = ERR_NOT_VENDOR;
        else if (bus.s_opcode[30:16] != 15'd0)          err_code = ERR_RSVD;
        else if (!func_legal)                           err_code = ERR_BAD_FUNC;
        else if ((fmt == 8'h00) || (is_conv && (src_fmt == 8'h00)))
                                                        err_code = ERR_BAD_FMT;
        else if (mode_raw >= 3'd3)                      err_code = ERR_BAD_MODE;
        else if (!tier_ok)                              err_code = ERR_TIER;
        else                                            err_code = ERR_OK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid       <= 1'b0;
            bus.m_func        <= '0;
            bus.m_fmt         <= '0;
            bus.m_src_fmt     <= '0;
            bus.m_mode        <= '0;
            bus.m_res_reg_vld <= 1'b0;
            bus.m_res_reg     <= '0;
            bus.m_opnd_is_reg <= '0;
            bus.m_opnd_reg    <= '0;
            bus.m_tag         <= '0;
            bus.m_err         <= 1'b0;
            bus.m_err_code    <= '0;
        end else if (accept) begin
            // errored descriptors keep only func/fmt/tag so completion can report them
            bus.m_valid       <= 1'b1;
            bus.m_func        <= func;
            bus.m_fmt         <= fmt;
            bus.m_tag         <= bus.s_tag;
            bus.m_err         <= (err_code != ERR_OK);
            bus.m_err_code    <= err_code;
            bus.m_src_fmt     <= (err_code == ERR_OK) ? src_fmt       : 8'h00;
            bus.m_mode        <= (err_code == ERR_OK) ? mode_raw[1:0] : 2'd0;
            bus.m_res_reg_vld <= (err_code == ERR_OK) && res_vld;
            bus.m_res_reg     <= (err_code == ERR_OK) ? res_reg       : 4'h0;
            bus.m_opnd_is_reg <= (err_code == ERR_OK) ? opnd_is_reg   : 3'b000;
            bus.m_opnd_reg    <= (err_code == ERR_OK) ? opnd_reg      : 12'h000;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            dec_cnt <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (dec_cnt != 16'hFFFF)
                dec_cnt <= dec_cnt + 16'd1;
            if ((err_code != ERR_OK) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_am9513_cai_decoder.sv
// Randomized bench for am9513_cai_decoder against an in-order descriptor model.
module tb_am9513_cai_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cur_mode = 2'd2;
    logic        cnt_clr = 1'b0;
    logic [15:0] dec_cnt, err_cnt;

    am9513_cai_decoder_if bus ();

    am9513_cai_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cur_mode (cur_mode),
        .cnt_clr  (cnt_clr),
        .dec_cnt  (dec_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  func;
        logic [7:0]  fmt;
        logic [7:0]  src;
        logic [1:0]  mode;
        logic        rv;
        logic [3:0]  rr;
        logic [2:0]  ir;
        logic [11:0] regs;
        logic [7:0]  tag;
        logic        err;
        logic [2:0]  code;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   exp_dec = 0;
    int   exp_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit in_rng(int f, int lo, int hi);
        return (f >= lo) && (f <= hi);
    endfunction

    function automatic exp_t model(logic [31:0] op, logic [31:0] fl, logic [95:0] of,
                                   logic [7:0] tag, logic [1:0] cm);
        exp_t e;
        int   f    = int'(op[7:0]);
        int   fm   = int'(op[15:8]);
        bit   conv = (f == 16);
        int   mode;
        int   code;
        bit   legal, allowed;
        legal = in_rng(f, 1, 10) || in_rng(f, 16, 20) || in_rng(f, 32, 39);
        if (conv)       mode = int'(cm);
        else if (fl[0]) mode = int'(fl[3:1]);
        else            mode = int'(cm);
        case (mode)
            0:       allowed = in_rng(f, 1, 5) || in_rng(f, 16, 20) || in_rng(f, 32, 37);
            1:       allowed = in_rng(f, 1, 5) || (f == 16);
            2:       allowed = legal;
            default: allowed = 1'b0;
        endcase
        if (!op[31])                            code = 1;
        else if (op[30:16] != 0)                code = 2;
        else if (!legal)                        code = 3;
        else if (fm == 0 || (conv && fl[7:0] == 0)) code = 4;
        else if (mode >= 3)                     code = 5;
        else if (!allowed)                      code = 6;
        else                                    code = 0;
        e      = '0;
        e.func = op[7:0];
        e.fmt  = op[15:8];
        e.tag  = tag;
        e.err  = (code != 0);
        e.code = 3'(code);
        if (code == 0) begin
            e.src  = conv ? fl[7:0] : 8'h00;
            e.mode = 2'(mode);
            e.rv   = conv ? 1'b0 : fl[4];
            e.rr   = conv ? 4'h0 : fl[11:8];
            for (int i = 0; i < 3; i++) begin
                e.ir[i] = of[32*i];
                e.regs[4*i+:4] = of[32*i] ? of[32*i+8+:4] : 4'h0;
            end
        end
        return e;
    endfunction

    // one compare process: every mid-cycle, outputs vs queue head and counters vs model
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        if (rst) begin
            chk("s_ready_in_rst", {31'd0, bus.s_ready}, 32'd0);
            exp_q.delete();
            exp_dec = 0;
            exp_err = 0;
        end else begin
            chk("s_ready", {31'd0, bus.s_ready}, {31'd0, (!bus.m_valid || bus.m_ready)});
            chk("dec_cnt", {16'd0, dec_cnt}, exp_dec);
            chk("err_cnt", {16'd0, err_cnt}, exp_err);
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("m_func",        {24'd0, bus.m_func},        {24'd0, e.func});
                    chk("m_fmt",         {24'd0, bus.m_fmt},         {24'd0, e.fmt});
                    chk("m_src_fmt",     {24'd0, bus.m_src_fmt},     {24'd0, e.src});
                    chk("m_mode",        {30'd0, bus.m_mode},        {30'd0, e.mode});
                    chk("m_res_reg_vld", {31'd0, bus.m_res_reg_vld}, {31'd0, e.rv});
                    chk("m_res_reg",     {28'd0, bus.m_res_reg},     {28'd0, e.rr});
                    chk("m_opnd_is_reg", {29'd0, bus.m_opnd_is_reg}, {29'd0, e.ir});
                    chk("m_opnd_reg",    {20'd0, bus.m_opnd_reg},    {20'd0, e.regs});
                    chk("m_tag",         {24'd0, bus.m_tag},         {24'd0, e.tag});
                    chk("m_err",         {31'd0, bus.m_err},         {31'd0, e.err});
                    chk("m_err_code",    {29'd0, bus.m_err_code},    {29'd0, e.code});
                    if (bus.m_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                chk("lost_uop", 32'd0, 32'd1);
                exp_q.delete();
            end
            acc = bus.s_valid && bus.s_ready;
            if (cnt_clr) begin
                exp_dec = 0;
                exp_err = 0;
            end else if (acc) begin
                e = model(bus.s_opcode, bus.s_flags, bus.s_opnd_flags, bus.s_tag, cur_mode);
                if (exp_dec < 65535) exp_dec++;
                if (e.err && exp_err < 65535) exp_err++;
            end
            if (acc)
                exp_q.push_back(model(bus.s_opcode, bus.s_flags, bus.s_opnd_flags,
                                      bus.s_tag, cur_mode));
        end
    end

    task automatic set_desc(input logic [31:0] op, input logic [31:0] fl,
                            input logic [95:0] of, input logic [7:0] tag);
        bus.s_opcode     = op;
        bus.s_flags      = fl;
        bus.s_opnd_flags = of;
        bus.s_tag        = tag;
    endtask

    task automatic rand_desc();
        logic [31:0] op;
        logic [31:0] r;
        op = $urandom;
        op[31] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 7) != 0) op[30:16] = '0;
        case ($urandom_range(0, 4))
            0: op[7:0] = 8'($urandom_range(1, 10));
            1: op[7:0] = 8'($urandom_range(16, 20));
            2: op[7:0] = 8'($urandom_range(32, 39));
            3: op[7:0] = 8'h10;
            default: op[7:0] = 8'($urandom);
        endcase
        op[15:8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        r = $urandom;
        if ($urandom_range(0, 1) == 0) r[3:1] = 3'($urandom_range(0, 2));
        set_desc(op, r, {$urandom, $urandom, $urandom}, 8'($urandom));
    endtask

    // leaves s_valid low, returns at posedge+1 of the accepting edge
    task automatic send(input logic [31:0] op, input logic [31:0] fl,
                        input logic [95:0] of, input logic [7:0] tag);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        set_desc(op, fl, of, tag);
        bus.s_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        set_desc('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_dec_cnt", {16'd0, dec_cnt}, 32'd0);
        rst = 1'b0;

        cur_mode = 2'd2;
        send(32'h8000_0301, 32'h0, 96'h0, 8'h5A);
        chk("t1_m_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("t1_func", {24'd0, bus.m_func}, 32'h01);
        chk("t1_fmt", {24'd0, bus.m_fmt}, 32'h03);
        chk("t1_mode", {30'd0, bus.m_mode}, 32'd2);
        chk("t1_err", {31'd0, bus.m_err}, 32'd0);
        chk("t1_tag", {24'd0, bus.m_tag}, 32'h5A);
        chk("t1_dec_cnt", {16'd0, dec_cnt}, 32'd1);

        send(32'h0000_0301, 32'h0, 96'h0, 8'h01);
        chk("t2_code_not_vendor", {29'd0, bus.m_err_code}, 32'd1);
        chk("t2_err", {31'd0, bus.m_err}, 32'd1);
        send(32'h8001_0301, 32'h0, 96'h0, 8'h02);
        chk("t2_code_rsvd", {29'd0, bus.m_err_code}, 32'd2);
        send(32'h8000_0330, 32'h0, 96'h0, 8'h03);
        chk("t2_code_bad_func", {29'd0, bus.m_err_code}, 32'd3);
        chk("t2_err_cnt", {16'd0, err_cnt}, 32'd3);

        cur_mode = 2'd1;
        send(32'h8000_0320, 32'h0, 96'h0, 8'h10);
        chk("t3_code_tier", {29'd0, bus.m_err_code}, 32'd6);
        send(32'h8000_0320, 32'h5, 96'h0, 8'h11);
        chk("t3_ok_code", {29'd0, bus.m_err_code}, 32'd0);
        chk("t3_ok_mode", {30'd0, bus.m_mode}, 32'd2);
        send(32'h8000_0320, 32'h7, 96'h0, 8'h12);
        chk("t3_code_bad_mode", {29'd0, bus.m_err_code}, 32'd5);

        send(32'h8000_0410, 32'h0000_0F13, 96'h0, 8'h20);
        chk("t4_src_fmt", {24'd0, bus.m_src_fmt}, 32'h13);
        chk("t4_res_vld", {31'd0, bus.m_res_reg_vld}, 32'd0);
        chk("t4_res_reg", {28'd0, bus.m_res_reg}, 32'd0);
        chk("t4_mode", {30'd0, bus.m_mode}, 32'd1);
        send(32'h8000_0410, 32'h0, 96'h0, 8'h21);
        chk("t4_code_bad_fmt", {29'd0, bus.m_err_code}, 32'd4);

        cur_mode = 2'd2;
        send(32'h8000_0301, 32'h0000_0A11, 96'h0000_0F01_0000_0700_0000_0501, 8'h30);
        chk("t5_is_reg", {29'd0, bus.m_opnd_is_reg}, 32'b101);
        chk("t5_opnd_reg", {20'd0, bus.m_opnd_reg}, 32'hF05);
        chk("t5_res_vld", {31'd0, bus.m_res_reg_vld}, 32'd1);
        chk("t5_res_reg", {28'd0, bus.m_res_reg}, 32'hA);

        bus.m_ready = 1'b0;
        rand_desc();
        bus.s_valid = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("stall_m_valid", {31'd0, bus.m_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            rand_desc();
            cur_mode = 2'($urandom_range(0, 3));
        end
        bus.s_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rand_desc();
            cur_mode    = 2'($urandom_range(0, 3));
            bus.s_valid = $urandom_range(0, 3) != 0;
            bus.m_ready = $urandom_range(0, 3) != 0;
            cnt_clr     = ($urandom_range(0, 63) == 0);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        cnt_clr     = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;

        cur_mode = 2'd2;
        set_desc(32'h8000_0301, 32'h0, 96'h0, 8'h77);
        bus.s_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_dec_cnt", {16'd0, dec_cnt}, 32'hFFFF);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_dec_cnt", {16'd0, dec_cnt}, 32'd0);
        chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);

        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        chk("pre_rst_m_valid", {31'd0, bus.m_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_drop_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_drop_dec_cnt", {16'd0, dec_cnt}, 32'd0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
